instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue.sv | 101 ++++++++++
 tb/tb_instr_fetch_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Circular FIFO of {pc, instr} pairs between the fetch unit and decode.
// Optional macro FQ_BYPASS_EN: same-cycle push-to-decode forwarding when the queue is empty.
module instr_fetch_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [31:0]              push_pc,
   input  logic [31:0]              push_instr,
   output logic                     if_en,
   input  logic                     flush,
   input  logic                     pop,
   output logic                     d_valid,
   output logic [31:0]              d_pc,
   output logic [31:0]              d_instr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];

   logic empty;
   logic push_ok;
   logic pop_ok;
   logic wr_en;

   assign empty = (count == '0);
   // Full flag comes from registered state only, so fetch sees no path from pop.
   assign if_en = (count < FULL_COUNT);

`ifdef FQ_BYPASS_EN
   logic bypass_hit;
   logic bypass_take;

   // Gated by reset so d_valid stays low while reset is asserted.
   assign bypass_hit  = empty & push & ~flush & reset;
   assign bypass_take = bypass_hit & pop;
`endif

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      push_ok = push & if_en & ~flush;
      pop_ok  = pop & ~empty & ~flush;
      wr_en   = push_ok;
      d_valid = ~empty;
      d_pc    = '0;
      d_instr = '0;
`ifdef FQ_BYPASS_EN
      // A bypassed entry consumed in the same cycle is never stored.
      wr_en   = push_ok & ~bypass_take;
      d_valid = ~flush & (~empty | bypass_hit);
      if (d_valid) begin
         d_pc    = empty ? push_pc    : pc_mem[rd_ptr];
         d_instr = empty ? push_instr : instr_mem[rd_ptr];
      end
`else
      if (d_valid) begin
         d_pc    = pc_mem[rd_ptr];
         d_instr = instr_mem[rd_ptr];
      end
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; count gates every read, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         pc_mem[wr_ptr]    <= push_pc;
         instr_mem[wr_ptr] <= push_instr;
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: vector table, directed corner cases,
// and randomized traffic against a queue-based reference model.
module tb_instr_fetch_queue;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          push;
   logic [31:0]   push_pc;
   logic [31:0]   push_instr;
   logic          if_en;
   logic          flush;
   logic          pop;
   logic          d_valid;
   logic [31:0]   d_pc;
   logic [31:0]   d_instr;
   logic [CW-1:0] count;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t mq[$];

   typedef struct {
      logic        push;
      logic [31:0] pc;
      logic        pop;
      logic        flush;
      int          exp_count;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic        exp_if_en;
   } vec_t;

   vec_t vecs[10];

   instr_fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_pc    (push_pc),
      .push_instr (push_instr),
      .if_en      (if_en),
      .flush      (flush),
      .pop        (pop),
      .d_valid    (d_valid),
      .d_pc       (d_pc),
      .d_instr    (d_instr),
      .count      (count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return {pc[15:0], 16'h0013} ^ 32'h00A0_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Applies one cycle of inputs, checks the pre-edge outputs against the model,
   // clocks, then advances the model. Entered and left 1 time unit after a rising edge.
   task automatic cycle(input logic p, input logic [31:0] pc, input logic [31:0] instr,
                        input logic po, input logic fl);
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
      int          size;
      push = p; push_pc = pc; push_instr = instr; pop = po; flush = fl;
      #1;
      size      = mq.size();
      exp_valid = (size != 0);
      exp_pc    = 32'h0;
      exp_instr = 32'h0;
      if (size != 0) begin
         exp_pc    = mq[0].pc;
         exp_instr = mq[0].instr;
      end
`ifdef FQ_BYPASS_EN
      if (size == 0 && p) begin
         exp_valid = 1'b1;
         exp_pc    = pc;
         exp_instr = instr;
      end
      if (fl) begin
         exp_valid = 1'b0;
         exp_pc    = 32'h0;
         exp_instr = 32'h0;
      end
`endif
      check("model_count",   32'(count),   32'(size));
      check("model_if_en",   32'(if_en),   32'(size < DEPTH));
      check("model_d_valid", 32'(d_valid), 32'(exp_valid));
      check("model_d_pc",    d_pc,         exp_pc);
      check("model_d_instr", d_instr,      exp_instr);
      @(posedge clk);
      #1;
      if (fl) begin
         mq.delete();
      end else begin
         logic pop_ok;
         logic push_ok;
         pop_ok  = po && (size != 0);
         push_ok = p && (size < DEPTH);
`ifdef FQ_BYPASS_EN
         if (size == 0 && p && po)
            push_ok = 1'b0;
`endif
         if (pop_ok)
            void'(mq.pop_front());
         if (push_ok)
            mq.push_back('{pc: pc, instr: instr});
      end
   endtask

   task automatic idle();
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      // Fill, refuse when full, push+pop at full, drain, pop on empty.
      vecs[0] = '{1'b1, 32'h3000, 1'b0, 1'b0, 1, 1'b1, 32'h3000, 1'b1};
      vecs[1] = '{1'b1, 32'h3004, 1'b0, 1'b0, 2, 1'b1, 32'h3000, 1'b1};
      vecs[2] = '{1'b1, 32'h3008, 1'b0, 1'b0, 3, 1'b1, 32'h3000, 1'b1};
      vecs[3] = '{1'b1, 32'h300C, 1'b0, 1'b0, 4, 1'b1, 32'h3000, 1'b0};
      vecs[4] = '{1'b1, 32'h3010, 1'b0, 1'b0, 4, 1'b1, 32'h3000, 1'b0};
      vecs[5] = '{1'b1, 32'h3010, 1'b1, 1'b0, 3, 1'b1, 32'h3004, 1'b1};
      vecs[6] = '{1'b0, 32'h0,    1'b1, 1'b0, 2, 1'b1, 32'h3008, 1'b1};
      vecs[7] = '{1'b0, 32'h0,    1'b1, 1'b0, 1, 1'b1, 32'h300C, 1'b1};
      vecs[8] = '{1'b0, 32'h0,    1'b1, 1'b0, 0, 1'b0, 32'h0,    1'b1};
      vecs[9] = '{1'b0, 32'h0,    1'b1, 1'b0, 0, 1'b0, 32'h0,    1'b1};

      reset = 1'b0; push = 1'b0; push_pc = '0; push_instr = '0; pop = 1'b0; flush = 1'b0;
      #1;
      check("reset_count",   32'(count),   32'h0);
      check("reset_if_en",   32'(if_en),   32'h1);
      check("reset_d_valid", 32'(d_valid), 32'h0);
      check("reset_d_pc",    d_pc,         32'h0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) begin
         logic [31:0] ei;
         ei = vecs[i].exp_valid ? instr_of(vecs[i].exp_pc) : 32'h0;
         cycle(vecs[i].push, vecs[i].pc, instr_of(vecs[i].pc), vecs[i].pop, vecs[i].flush);
         check($sformatf("vec%0d_count", i),   32'(count),   32'(vecs[i].exp_count));
         check($sformatf("vec%0d_d_valid", i), 32'(d_valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d_d_pc", i),    d_pc,         vecs[i].exp_pc);
         check($sformatf("vec%0d_d_instr", i), d_instr,      ei);
         check($sformatf("vec%0d_if_en", i),   32'(if_en),   32'(vecs[i].exp_if_en));
      end

      // Wrap-around: ten push+pop cycles holding two entries.
      cycle(1'b1, 32'h5000, instr_of(32'h5000), 1'b0, 1'b0);
      cycle(1'b1, 32'h5004, instr_of(32'h5004), 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         logic [31:0] npc;
         npc = 32'h5000 + 32'(4 * (k + 2));
         cycle(1'b1, npc, instr_of(npc), 1'b1, 1'b0);
         check("wrap_count", 32'(count), 32'h2);
         check("wrap_d_pc",  d_pc,       32'h5000 + 32'(4 * (k + 1)));
      end

      // Flush with push and pop at count=3, then a fresh push.
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("flush_pre_count", 32'(count), 32'h1);
      idle();
      check("flush_setup_count", 32'(count), 32'h1);
      cycle(1'b1, 32'h6000, instr_of(32'h6000), 1'b0, 1'b0);
      check("flush_setup3_count", 32'(count), 32'h2);
      cycle(1'b1, 32'h6004, instr_of(32'h6004), 1'b0, 1'b0);
      check("flush_at3_count", 32'(count), 32'h3);
      cycle(1'b1, 32'hDEAD, instr_of(32'hDEAD), 1'b1, 1'b1);
      check("flush_count",   32'(count),   32'h0);
      check("flush_d_valid", 32'(d_valid), 32'h0);
      check("flush_if_en",   32'(if_en),   32'h1);
      cycle(1'b1, 32'h4000, instr_of(32'h4000), 1'b0, 1'b0);
      check("after_flush_d_pc",   d_pc,       32'h4000);
      check("after_flush_count",  32'(count), 32'h1);
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("after_flush_empty",  32'(count), 32'h0);

      // Asynchronous reset mid-cycle with count=3.
      for (int k = 0; k < 3; k++)
         cycle(1'b1, 32'h7000 + 32'(4 * k), instr_of(32'h7000 + 32'(4 * k)), 1'b0, 1'b0);
      check("pre_reset_count", 32'(count), 32'h3);
      push = 1'b0; pop = 1'b0; flush = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("async_reset_count",   32'(count),   32'h0);
      check("async_reset_d_valid", 32'(d_valid), 32'h0);
      check("async_reset_if_en",   32'(if_en),   32'h1);
      check("async_reset_d_pc",    d_pc,         32'h0);
      mq.delete();
      #3 reset = 1'b1;
      @(posedge clk);
      #1;
      idle();

`ifdef FQ_BYPASS_EN
      // Same-cycle forwarding into an empty queue that decode consumes at once.
      push = 1'b1; push_pc = 32'h3000; push_instr = 32'h2401_0001; pop = 1'b1; flush = 1'b0;
      #1;
      check("bypass_d_valid", 32'(d_valid), 32'h1);
      check("bypass_d_pc",    d_pc,         32'h3000);
      check("bypass_d_instr", d_instr,      32'h2401_0001);
      cycle(1'b1, 32'h3000, 32'h2401_0001, 1'b1, 1'b0);
      check("bypass_count", 32'(count), 32'h0);
`endif

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic        p;
         logic        po;
         logic        fl;
         logic [31:0] rpc;
         p   = ($urandom_range(0, 99) < 60);
         po  = ($urandom_range(0, 99) < 55);
         fl  = ($urandom_range(0, 99) < 5);
         rpc = $urandom;
         cycle(p, rpc, $urandom, po, fl);
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
